// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control-token constants, aligner state and token lookup.
// Shared by tmds_word_decode and tmds_channel_decoder.
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  // Returns {hit, ctrl[1:0]}
  function automatic logic [2:0] is_ctrl_token(
    input logic [9:0] word
  );
    logic [2:0] r;
    r = 3'b000;
    case (word)
      TMDS_CTRL_00: r = 3'b100;
      TMDS_CTRL_01: r = 3'b101;
      TMDS_CTRL_10: r = 3'b110;
      TMDS_CTRL_11: r = 3'b111;
      default:      r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational 10b->8b TMDS decode plus token detect.
// Ports: i_word aligned word; o_data byte; o_ctrl {C1,C0}; o_is_ctrl hit.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_word,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_is_ctrl
);

  logic [7:0] w_q;
  logic [6:0] w_x;
  logic [2:0] w_tok;

  // Undo the optional inversion, then the XOR/XNOR chain.
  assign w_q    = i_word[9] ? ~i_word[7:0] : i_word[7:0];
  assign w_x    = w_q[7:1] ^ w_q[6:0];
  assign o_data = {i_word[8] ? w_x : ~w_x, w_q[0]};

  assign w_tok     = is_ctrl_token(i_word);
  assign o_is_ctrl = w_tok[2];
  assign o_ctrl    = w_tok[1:0];

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: word-boundary search on control-token runs + decode.
// Ports: clk, reset_n, raw_word, realign in; video_data, ctrl, de,
//        locked, bit_offset out (all registered).
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] raw_word,
  input  logic       realign,
  output logic [7:0] video_data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int TW = $clog2(LOSS_TIMEOUT + 1);

  align_state_t r_state, w_state_nx;

  logic [9:0]    r_prev;
  logic [9:0]    r_aligned;
  logic [3:0]    r_off, w_off_nx;
  logic [RW-1:0] r_run, w_run_nx, w_run_inc;
  logic [TW-1:0] r_tmo, w_tmo_nx;
  logic [7:0]    r_data;
  logic [1:0]    r_ctrl;
  logic          r_de, w_de_nx;

  logic [19:0] w_pair;
  logic [9:0]  w_window;
  logic [7:0]  w_dec;
  logic [1:0]  w_tctrl;
  logic        w_hit;
  logic        w_qual;
  logic        w_adv;

  // Older word sits in the low half: bit 0 is first on the wire.
  assign w_pair   = {raw_word, r_prev};
  assign w_window = w_pair[r_off +: 10];

  tmds_word_decode u_dec (
    .i_word    (r_aligned),
    .o_data    (w_dec),
    .o_ctrl    (w_tctrl),
    .o_is_ctrl (w_hit)
  );

  always_comb begin
    w_run_inc = (r_run == RW'(LOCK_RUN)) ? r_run
                                         : r_run + 1'b1;
    w_qual     = w_hit && (w_run_inc == RW'(LOCK_RUN));
    w_state_nx = r_state;
    w_adv      = 1'b0;
    w_run_nx   = w_hit ? w_run_inc : '0;
    w_tmo_nx   = (r_tmo == TW'(LOSS_TIMEOUT)) ? r_tmo
                                              : r_tmo + 1'b1;
    // realign wins over a run or a timeout in the same cycle
    if (realign) begin
      w_state_nx = SEARCH;
      w_adv      = 1'b1;
      w_run_nx   = '0;
      w_tmo_nx   = '0;
    end else if (w_qual) begin
      w_state_nx = LOCKED;
      w_tmo_nx   = '0;
    end else begin
      unique case (r_state)
        SEARCH: begin
          if (r_tmo == TW'(SEARCH_TIMEOUT - 1)) begin
            w_adv    = 1'b1;
            w_run_nx = '0;
            w_tmo_nx = '0;
          end
        end
        LOCKED: begin
          if (r_tmo == TW'(LOSS_TIMEOUT - 1)) begin
            w_state_nx = SEARCH;
            w_tmo_nx   = '0;
          end
        end
        default: ;
      endcase
    end
    w_off_nx = r_off;
    if (w_adv) begin
      w_off_nx = (r_off == 4'd9) ? 4'd0 : r_off + 4'd1;
    end
    w_de_nx = (w_state_nx == LOCKED) && !w_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= SEARCH;
      r_prev    <= '0;
      r_aligned <= '0;
      r_off     <= '0;
      r_run     <= '0;
      r_tmo     <= '0;
      r_data    <= '0;
      r_ctrl    <= '0;
      r_de      <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_prev    <= raw_word;
      r_aligned <= w_window;
      r_off     <= w_off_nx;
      r_run     <= w_run_nx;
      r_tmo     <= w_tmo_nx;
      r_de      <= w_de_nx;
      r_data    <= w_de_nx ? w_dec : '0;
      if (w_hit) begin
        r_ctrl <= w_tctrl;
      end
    end
  end

  assign video_data = r_data;
  assign ctrl       = r_ctrl;
  assign de         = r_de;
  assign locked     = (r_state == LOCKED);
  assign bit_offset = r_off;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed + random stimulus against a
// bit-stream reference model of the TMDS channel decoder.
module tb_tmds_channel_decoder;

  localparam int LR = 8;
  localparam int ST = 4096;
  localparam int LT = 8192;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] raw_word = '0;
  logic       realign = 1'b0;
  logic [7:0] video_data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] bit_offset;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .LOCK_RUN       (LR),
    .SEARCH_TIMEOUT (ST),
    .LOSS_TIMEOUT   (LT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_word   (raw_word),
    .realign    (realign),
    .video_data (video_data),
    .ctrl       (ctrl),
    .de         (de),
    .locked     (locked),
    .bit_offset (bit_offset)
  );

  int n_chk = 0;
  int n_fail = 0;
  int ticks = 0;
  int lw = 0;

  int m_off, m_run, m_idle, m_lock;
  int m_prev, m_aln;
  int e_data, e_ctrl, e_de;

  function automatic int tok_code(input int w);
    case (w)
      'h354:   return 0;
      'h0AB:   return 1;
      'h154:   return 2;
      'h2AB:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int ref_decode(input int w);
    int q, r, x;
    q = ((w >> 9) & 1) ? (~w & 'hFF) : (w & 'hFF);
    r = q & 1;
    for (int i = 1; i < 8; i++) begin
      x = ((q >> i) ^ (q >> (i - 1))) & 1;
      if (((w >> 8) & 1) == 0) x = x ^ 1;
      r = r | (x << i);
    end
    return r;
  endfunction

  function automatic bit m_will_qual();
    return (tok_code(m_aln) >= 0) && (m_run >= LR - 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
      if (n_fail >= 40) begin
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
      end
    end
  endtask

  task automatic m_reset();
    m_off = 0; m_run = 0; m_idle = 0; m_lock = 0;
    m_prev = 0; m_aln = 0;
    e_data = 0; e_ctrl = 0; e_de = 0;
  endtask

  // One clock edge of the reference: what the channel sees this cycle.
  task automatic m_step(input int raw, input bit rl);
    int t, rn, na;
    t  = tok_code(m_aln);
    rn = (t >= 0) ? ((m_run < LR) ? m_run + 1 : LR) : 0;
    na = ((((raw << 10) | m_prev) >> m_off) & 'h3FF);
    if (rl) begin
      m_off = (m_off + 1) % 10;
      m_lock = 0; m_run = 0; m_idle = 0;
    end else if (rn == LR) begin
      m_lock = 1; m_run = rn; m_idle = 0;
    end else if (m_lock != 0 && m_idle == LT - 1) begin
      m_lock = 0; m_run = rn; m_idle = 0;
    end else if (m_lock == 0 && m_idle == ST - 1) begin
      m_off = (m_off + 1) % 10;
      m_run = 0; m_idle = 0;
    end else begin
      m_run = rn;
      if (m_idle < LT) m_idle++;
    end
    e_de   = (m_lock != 0 && t < 0) ? 1 : 0;
    e_data = (e_de != 0) ? ref_decode(m_aln) : 0;
    if (t >= 0) e_ctrl = t;
    m_aln  = na;
    m_prev = raw;
  endtask

  task automatic tick(input int raw, input bit rl);
    int ex;
    raw_word = raw[9:0];
    realign  = rl;
    m_step(raw, rl);
    @(posedge clk);
    #1;
    realign = 1'b0;
    ticks++;
    ex = (m_lock << 15) | (m_off << 11) | (e_de << 10)
       | (e_ctrl << 8) | e_data;
    chk("outs", {16'h0, locked, bit_offset, de, ctrl, video_data}, ex);
  endtask

  // Send word w on a wire whose word boundary lags by d bits.
  task automatic send(input int w, input int d, input bit rl);
    int raw;
    raw = ((((w << 10) | lw) >> (10 - d)) & 'h3FF);
    lw = w;
    tick(raw, rl);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    raw_word = '0;
    realign = 1'b0;
    #2;
    chk("rst_async",
        {16'h0, locked, bit_offset, de, ctrl, video_data}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    lw = 0;
    ticks = 0;
    m_reset();
    chk("off_after_rst", bit_offset, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, j, nchg;
    int chg[3];
    bit hit;
    logic [3:0] po;

    #1;
    do_reset();

    // Offset 0 lock and pipeline timing
    for (int i = 0; i < 8; i++) send('h354, 0, 0);
    send('h100, 0, 0);
    chk("lock_pre", locked, 0);
    send('h3FF, 0, 0);
    chk("lock_8th", locked, 1);
    chk("ctrl_tok", ctrl, 0);
    chk("de_tok", de, 0);
    send('h354, 0, 0);
    chk("de_d0", de, 1);
    chk("vd_d0", video_data, 8'h00);
    send('h354, 0, 0);
    chk("de_d1", de, 1);
    chk("vd_d1", video_data, 8'h00);

    // Hsync-like blanking with random active video
    for (int ln = 0; ln < 6; ln++) begin
      for (int k = 0; k < 10; k++)
        send((ln % 2) ? 'h354 : 'h154, 0, 0);
      for (int k = 0; k < 16; k++) begin
        do w = int'($urandom_range(0, 1023));
        while (tok_code(w) >= 0);
        send(w, 0, 0);
      end
      chk("hs_ctrl", ctrl, (ln % 2) ? 0 : 2);
      chk("hs_de", de, 1);
    end

    // Loss of lock
    for (int k = 0; k < 8; k++) send('h354, 0, 0);
    n = 0;
    for (int k = 1; k <= LT + 100; k++) begin
      send('h100, 0, 0);
      n = k;
      if (!locked) break;
    end
    chk("loss_cycles", n, LT + 2);
    chk("loss_de", de, 0);
    chk("loss_off", bit_offset, 0);

    // Lock at offset 5, then async reset mid-lock
    for (int k = 0; k < 5; k++) send('h100, 0, 1);
    for (int k = 0; k < 40; k++) begin
      send('h354, 5, 0);
      if (locked) break;
    end
    chk("lock5", locked, 1);
    chk("off5", bit_offset, 5);
    do_reset();

    // Search from offset 0 to a stream lagging by 3 bits
    nchg = 0;
    j = 0;
    po = bit_offset;
    for (int k = 0; k < 20000; k++) begin
      send((j < 8) ? 'h0AB : 'h3FF, 3, 0);
      j = (j == 8) ? 0 : j + 1;
      if (bit_offset != po) begin
        if (nchg < 3) chg[nchg] = ticks;
        nchg++;
        po = bit_offset;
      end
      if (locked) break;
    end
    chk("search_lock", locked, 1);
    chk("search_nstep", nchg, 3);
    chk("search_t1", chg[0], ST);
    chk("search_t2", chg[1], 2 * ST);
    chk("search_t3", chg[2], 3 * ST);
    chk("search_off", bit_offset, 3);
    chk("search_ctrl", ctrl, 1);

    // Realign on the cycle the 8th token arrives at offset 9
    do_reset();
    for (int k = 0; k < 9; k++) send('h100, 0, 1);
    chk("off9", bit_offset, 9);
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_will_qual()) begin
        send('h354, 9, 1);
        hit = 1'b1;
        break;
      end
      send('h354, 9, 0);
    end
    chk("rl_hit", hit, 1);
    chk("rl_locked", locked, 0);
    chk("rl_off", bit_offset, 0);
    for (int k = 0; k < 12; k++) send('h354, 9, 0);
    chk("rl_stay", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the DVI TMDS transmit path, for one TMDS channel.
- Input is 10-bit raw words from an external deserializer at pixel rate, at arbitrary bit phase; no bitslip control is fed back to the deserializer.
- The block finds the word boundary from runs of control tokens, then decodes each aligned word to 8-bit video data, or to 2-bit control data with DE.
- Three instances, one per channel, feed a future capture/sync-recovery block.

Parameters:
- LOCK_RUN, 8: consecutive identical-offset control tokens required to declare lock.
- SEARCH_TIMEOUT, 4096: cycles without a qualifying run before the search advances the bit offset.
- LOSS_TIMEOUT, 8192: cycles without a qualifying run while locked before lock is dropped.

Ports:
- clk  in  1  pixel clock; raw_word is synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- raw_word  in  10  deserialized bits; bit 0 was received first.
- realign  in  1  single-cycle pulse: drop lock and advance the offset.
- video_data  out  8  decoded pixel byte, valid when de=1.
- ctrl  out  2  decoded control bits {C1,C0}; hold their last value while de=1.
- de  out  1  data enable: aligned word is not a control token.
- locked  out  1  alignment achieved.
- bit_offset  out  4  current window offset, 0..9.

Behaviour:
- Reset (reset_n=0, async): all outputs 0, offset 0, state SEARCH, all counters 0, previous-word register 0.
- Aligner:
  - prev register holds the previous raw_word.
  - Window = {raw_word, prev}[bit_offset +: 10].
  - aligned_reg <= window each clk.
- Control tokens (aligned word → ctrl):
  - 0x354 → 00
  - 0x0AB → 01
  - 0x154 → 10
  - 0x2AB → 11
- Decode, for a non-token word d:
  - q = d[9] ? ~d[7:0] : d[7:0].
  - data[0] = q[0].
  - data[i] = d[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), for i = 1..7.
- Latency: a window containing raw_word sampled at edge N appears on the outputs after edge N+1 (two register stages).
- Output gating: when locked=0, de=0 and video_data=0; ctrl still tracks decoded tokens (diagnostic only).
- run_cnt:
  - Increments on each aligned control token and resets to 0 on a non-token word.
  - Saturates at LOCK_RUN; "qualifying run" means run_cnt reaches LOCK_RUN.
  - Width is clog2(LOCK_RUN+1).
- tmo_cnt:
  - Increments every cycle and clears on a qualifying run or on any state change.
  - Width is clog2(LOSS_TIMEOUT+1); it never wraps.
- FSM SEARCH:
  - Qualifying run → LOCKED, locked=1 on the same edge the outputs first show the run's last token.
  - tmo_cnt == SEARCH_TIMEOUT-1 → bit_offset advances (9 wraps to 0); run_cnt and tmo_cnt clear; state stays SEARCH.
- FSM LOCKED:
  - tmo_cnt == LOSS_TIMEOUT-1 → SEARCH, locked=0, bit_offset unchanged.
  - Active video may contain any non-token word; this never drops lock by itself.
- realign pulse: from either state go to SEARCH, advance bit_offset, clear counters, locked=0.
  - Realign beats a simultaneous qualifying run.
  - Realign beats a simultaneous timeout; the offset advances exactly once.
- After an offset change, the first window at the new offset is visible one cycle later. The run counter ignores the single transition word, because it is already cleared.
- No combinational path from inputs to outputs.

Decomposition:
- Package tmds_pkg:
  - TMDS_CTRL_00/01/10/11 token constants.
  - align_state_t enum {SEARCH, LOCKED}.
  - function is_ctrl_token(word) → {hit, ctrl[1:0]}.
- Sub-module tmds_word_decode: purely combinational 10→8 decode plus token detect. It is reused later by the three-channel capture block and by verification as a reference model.

Test Plan:
- Offset 0, lock and timing: reset, then 8× 0x354 followed by 0x100 and 0x3FF.
  - Required: locked=1 after the 8th token propagates; ctrl=00, de=0 during tokens.
  - Then de=1 with video_data=0x00 for both data words; data appears two edges after input.
- Offset 3 search: stream of 0x0AB tokens delayed by 3 bits.
  - Required: bit_offset steps 0→1→2→3 at SEARCH_TIMEOUT intervals, then locks; ctrl=01; bit_offset stays 3.
- Loss of lock: lock, then drive 0x100 continuously for LOSS_TIMEOUT cycles.
  - Required: locked falls exactly at cycle LOSS_TIMEOUT, de forced 0, bit_offset retained.
- Realign priority: pulse realign on the same cycle the 8th token arrives at offset 9.
  - Required: locked stays 0, bit_offset wraps to 0, run_cnt cleared.
- Async reset mid-lock: assert reset_n=0 between edges while locked at offset 5.
  - Required: all outputs 0 immediately, without a clock edge; bit_offset=0 after release.
- Hsync tracking: alternating blanking lines of 0x154/0x354 between active data.
  - Required: ctrl follows 10/00 and holds its last value while de=1.
